// File: rtl/tisc_pkg.sv
// Shared definitions for the TISC instruction-memory loader.
//   LDR_INSTR_W   : instruction word width (two stream bytes per word)
//   LDR_SYNC_BYTE : default frame start marker
//   ldr_state_t   : loader FSM state encoding
package tisc_pkg;

  localparam int         LDR_INSTR_W   = 16;
  localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

  // Frame completion (done) and rejection (error) are taken on the
  // transition edge straight back to ST_IDLE, so they need no state of
  // their own.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5
  } ldr_state_t;

endpackage

// File: rtl/imem_loader_csum.sv
// Running 8-bit modulo-256 checksum for a load frame.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : restart the sum (frame start)
//   i_add    : accumulate i_data
//   i_data   : stream byte (also the value compared against)
//   o_match  : running sum equals i_data
module imem_loader_csum
  import tisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_data,
  output logic       o_match
);

  logic [7:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sum <= 8'd0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match = (r_sum == i_data);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles 16-bit words from a framed byte
// stream (SYNC, count N, N words high byte first) and writes them into
// instruction memory from address 0, holding the CPU until a good load.
// Optional trailing checksum byte enabled by the IMEM_LOADER_CSUM_EN macro.
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : stream byte          in_valid / in_ready : handshake
//   imem_we     : one-cycle write strobe per word
//   imem_addr   : write address        imem_wdata : write data
//   cpu_hold    : processor held       load_done / load_err : frame status
module imem_loader
  import tisc_pkg::*;
#(
  parameter int         INSTR_W   = LDR_INSTR_W,
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = LDR_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  ldr_state_t         r_state;
  logic [ADDR_W-1:0]  r_waddr;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic [INSTR_W-1:0] r_imem_wdata;
  logic [7:0]         r_hi;
  logic [7:0]         r_remain;
  logic               r_we;
  logic               r_hold;
  logic               r_done;
  logic               r_err;
  logic               w_xfer;

  // The only stall is the memory write cycle.
  assign in_ready = (r_state != ST_WRITE);
  assign w_xfer   = in_valid && in_ready;

`ifdef IMEM_LOADER_CSUM_EN
  logic w_csum_ok;
  logic w_csum_clr;
  logic w_csum_add;

  assign w_csum_clr = w_xfer && (r_state == ST_IDLE) && (in_data == SYNC_BYTE);
  assign w_csum_add = w_xfer && ((r_state == ST_COUNT) || (r_state == ST_HI) ||
                                 (r_state == ST_LO));

  imem_loader_csum u_csum (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_csum_clr),
    .i_add   (w_csum_add),
    .i_data  (in_data),
    .o_match (w_csum_ok)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_waddr      <= '0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_hi         <= 8'd0;
      r_remain     <= 8'd0;
      r_we         <= 1'b0;
      r_hold       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && (in_data == SYNC_BYTE)) begin
            r_state <= ST_COUNT;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (w_xfer) begin
            r_remain <= in_data;
            r_waddr  <= '0;
            if (in_data == 8'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
              r_state <= ST_CSUM;
`else
              r_state <= ST_IDLE;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else if (32'(in_data) > MAX_WORDS) begin
              // Would overrun the address space: reject before any write.
              r_state <= ST_IDLE;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_HI;
            end
          end
        end
        ST_HI: begin
          if (w_xfer) begin
            r_hi    <= in_data;
            r_state <= ST_LO;
          end
        end
        ST_LO: begin
          if (w_xfer) begin
            r_imem_addr  <= r_waddr;
            r_imem_wdata <= INSTR_W'({r_hi, in_data});
            r_we         <= 1'b1;
            r_state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Output address register stays put; only the counter advances.
          r_waddr  <= r_waddr + ADDR_W'(1);
          r_remain <= r_remain - 8'd1;
          if (r_remain != 8'd1) begin
            r_state <= ST_HI;
          end else begin
`ifdef IMEM_LOADER_CSUM_EN
            r_state <= ST_CSUM;
`else
            r_state <= ST_IDLE;
            r_hold  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM: begin
          if (w_xfer) begin
            r_state <= ST_IDLE;
            if (w_csum_ok) begin
              r_hold <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: instance A uses ADDR_W=8, instance B
// uses ADDR_W=4 for the address-space boundary cases. Checksum bytes are
// appended when IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;

`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'd0;
  logic        va = 1'b0;
  logic        vb = 1'b0;

  logic        a_rdy, a_we, a_hold, a_done, a_err;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata;
  logic        b_rdy, b_we, b_hold, b_done, b_err;
  logic [3:0]  b_addr;
  logic [15:0] b_wdata;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) u_a (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(va), .in_ready(a_rdy),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .cpu_hold(a_hold), .load_done(a_done), .load_err(a_err));

  imem_loader #(.ADDR_W(4)) u_b (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vb), .in_ready(b_rdy),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .cpu_hold(b_hold), .load_done(b_done), .load_err(b_err));

  int n_total = 0;
  int n_bad   = 0;
  int na = 0, nb = 0, rdy_bad = 0;
  logic [7:0]  wa_addr [0:63];
  logic [15:0] wa_data [0:63];
  logic [3:0]  wb_addr [0:63];
  logic [15:0] wb_data [0:63];
  logic [15:0] fw [0:31];
  bit rnd_gap = 1'b0;

  // Write log, plus in_ready must be exactly the inverse of the write strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_we) begin
        if (na < 64) begin wa_addr[na] = a_addr; wa_data[na] = a_wdata; end
        na++;
      end
      if (b_we) begin
        if (nb < 64) begin wb_addr[nb] = b_addr; wb_data[nb] = b_wdata; end
        nb++;
      end
      if (a_we == a_rdy) rdy_bad++;
      if (b_we == b_rdy) rdy_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input bit sel, input logic [7:0] b);
    bit ok;
    bit r;
    int gap;
    gap = rnd_gap ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    din = b;
    if (sel) vb = 1'b1; else va = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      r = sel ? b_rdy : a_rdy;
      @(posedge clk); #1;
      if (r) ok = 1'b1;
    end
    va = 1'b0;
    vb = 1'b0;
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Sync, count, words fw[0..nw-1], then the checksum when enabled.
  task automatic send_frame(input bit sel, input logic [7:0] cnt, input int nw);
    logic [7:0] s;
    s = cnt;
    send(sel, 8'hA5);
    send(sel, cnt);
    for (int i = 0; i < nw; i++) begin
      send(sel, fw[i][15:8]);
      send(sel, fw[i][7:0]);
      s = s + fw[i][15:8] + fw[i][7:0];
    end
    if (CSUM) send(sel, s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_hold", a_hold, 1);
    chk("rst_ready", a_rdy, 1);
    chk("rst_we", a_we, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);

    // Two-word frame with latency checks
    send(0, 8'hA5);
    send(0, 8'h02);
    send(0, 8'h12);
    send(0, 8'h34);
    chk("w0_we", a_we, 1);
    chk("w0_ready", a_rdy, 0);
    chk("w0_addr", a_addr, 8'h00);
    chk("w0_data", a_wdata, 16'h1234);
    send(0, 8'hAB);
    send(0, 8'hCD);
    chk("w1_we", a_we, 1);
    chk("w1_addr", a_addr, 8'h01);
    chk("w1_data", a_wdata, 16'hABCD);
    chk("w1_hold_during_write", a_hold, 1);
    if (CSUM) send(0, 8'hC0);
    else idle(1);
    chk("f1_hold", a_hold, 0);
    chk("f1_done", a_done, 1);
    chk("f1_we_off", a_we, 0);
    chk("f1_addr_held", a_addr, 8'h01);
    idle(2);
    chk("f1_nwrites", na, 2);
    chk("f1_log0", {wa_addr[0], wa_data[0]}, {8'h00, 16'h1234});
    chk("f1_log1", {wa_addr[1], wa_data[1]}, {8'h01, 16'hABCD});

    // Junk then empty frame
    n0 = na;
    send(0, 8'h00);
    send(0, 8'hFF);
    chk("junk_done_kept", a_done, 1);
    send(0, 8'hA5);
    chk("sync_clears_done", a_done, 0);
    chk("sync_sets_hold", a_hold, 1);
    send(0, 8'h00);
    if (CSUM) send(0, 8'h00);
    chk("empty_hold", a_hold, 0);
    chk("empty_done", a_done, 1);
    idle(2);
    chk("empty_nwrites", na, n0);

`ifdef IMEM_LOADER_CSUM_EN
    // Good and bad checksum
    n0 = na;
    send(0, 8'hA5); send(0, 8'h01); send(0, 8'h12); send(0, 8'h34);
    send(0, 8'h47);
    chk("csum_ok_done", a_done, 1);
    chk("csum_ok_hold", a_hold, 0);
    idle(2);
    chk("csum_ok_write", {wa_addr[n0], wa_data[n0]}, {8'h00, 16'h1234});
    send(0, 8'hA5); send(0, 8'h01); send(0, 8'h12); send(0, 8'h34);
    send(0, 8'h48);
    chk("csum_bad_err", a_err, 1);
    chk("csum_bad_hold", a_hold, 1);
    chk("csum_bad_done", a_done, 0);
    idle(2);
`endif

    // Random valid gaps
    n0 = na;
    rnd_gap = 1'b1;
    fw[0] = 16'hBEEF;
    send_frame(0, 8'h01, 1);
    rnd_gap = 1'b0;
    idle(3);
    chk("gap_nwrites", na, n0 + 1);
    chk("gap_write", {wa_addr[n0], wa_data[n0]}, {8'h00, 16'hBEEF});
    chk("gap_done", a_done, 1);

    // Reset mid-frame, then reload
    n0 = na;
    send(0, 8'hA5); send(0, 8'h03);
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_hold", a_hold, 1);
    chk("abort_we", a_we, 0);
    chk("abort_done", a_done, 0);
    chk("abort_addr", a_addr, 0);
    idle(4);
    chk("abort_nwrites", na, n0 + 1);
    fw[0] = 16'hDEAD; fw[1] = 16'h0001;
    send_frame(0, 8'h02, 2);
    idle(3);
    chk("reload_nwrites", na, n0 + 3);
    chk("reload_w0", {wa_addr[n0+1], wa_data[n0+1]}, {8'h00, 16'hDEAD});
    chk("reload_w1", {wa_addr[n0+2], wa_data[n0+2]}, {8'h01, 16'h0001});
    chk("reload_done", a_done, 1);
    chk("reload_hold", a_hold, 0);

    // Address-space boundary on the 4-bit instance
    send(1, 8'hA5);
    send(1, 8'h11);
    chk("over_err", b_err, 1);
    chk("over_hold", b_hold, 1);
    idle(3);
    chk("over_nwrites", nb, 0);
    for (int i = 0; i < 16; i++) fw[i] = {8'(i), 8'(8'hF0 ^ i)};
    send_frame(1, 8'h10, 16);
    idle(3);
    chk("full_nwrites", nb, 16);
    chk("full_done", b_done, 1);
    chk("full_err", b_err, 0);
    chk("full_hold", b_hold, 0);
    for (int i = 0; i < 16; i++)
      chk("full_log", {12'd0, wb_addr[i], wb_data[i]},
          {12'd0, 4'(i), 8'(i), 8'(8'hF0 ^ i)});

    chk("ready_vs_we", rdy_bad, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
